// File: rtl/bus_response_mux_pkg.sv
// Shared CPU data-bus definitions: response tags, tracking entry layout and
// the address map the decoder works from.
package bus_response_mux_pkg;

    // Which target a tracked request belongs to.
    typedef enum logic [1:0] {
        TAG_DMEM   = 2'd0,
        TAG_HWREGS = 2'd1,
        TAG_IMEM   = 2'd2,
        TAG_ERR    = 2'd3
    } tag_e;

    // One outstanding request as stored in the tracking FIFO.
    typedef struct packed {
        tag_e        tag;
        logic [31:0] address;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Address map shared with the decoder.
    localparam logic [31:0] DMEM_BASE    = 32'h0000_0000;
    localparam logic [31:0] DMEM_LIMIT   = 32'h0000_FFFF;
    localparam logic [31:0] HWREGS_BASE  = 32'hE000_0000;
    localparam logic [31:0] HWREGS_LIMIT = 32'hE000_FFFF;
    localparam logic [31:0] IMEM_BASE    = 32'hFFFF_0000;

    // Selects are {error, imem, hwregs, dmem}; anything that is not exactly
    // one target select becomes an error request.
    function automatic tag_e decode_tag(input logic [3:0] sel);
        tag_e tag;
        case (sel)
            4'b0001: tag = TAG_DMEM;
            4'b0010: tag = TAG_HWREGS;
            4'b0100: tag = TAG_IMEM;
            default: tag = TAG_ERR;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/bus_response_mux_if.sv
// CPU data-bus return path signals: CPU request side, decoder selects,
// target responses and the response back to the CPU.
interface bus_response_mux_if;
    logic        cpu_request;
    logic [31:0] cpu_address;
    logic        dmem_request;
    logic        hwregs_request;
    logic        imem_request;
    logic        error_request;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        hwregs_ack;
    logic [31:0] hwregs_rdata;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        cpu_stall;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_error;
    logic [31:0] cpu_error_address;

    // Response mux side.
    modport slave (
        input  cpu_request, cpu_address,
        input  dmem_request, hwregs_request, imem_request, error_request,
        input  dmem_ack, dmem_rdata, hwregs_ack, hwregs_rdata, imem_ack, imem_rdata,
        output cpu_stall, cpu_ack, cpu_rdata, cpu_error, cpu_error_address
    );

    // CPU / decoder / target side.
    modport master (
        output cpu_request, cpu_address,
        output dmem_request, hwregs_request, imem_request, error_request,
        output dmem_ack, dmem_rdata, hwregs_ack, hwregs_rdata, imem_ack, imem_rdata,
        input  cpu_stall, cpu_ack, cpu_rdata, cpu_error, cpu_error_address
    );
endinterface

// File: rtl/bus_response_mux_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count.
// Head data is visible combinationally; storage is not reset.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == {CW{1'b0}});
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_push_s = push & (~full | pop);
        do_pop_s  = pop & ~empty;
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/bus_response_mux.sv
// CPU data-bus return path. Records every decoded request in order and
// returns the head request's target acknowledge and read data to the CPU,
// or a bus error for decoder error requests.
// Optional build macro BUS_TIMEOUT_EN: a head request waiting TIMEOUT cycles
// for its target is answered with a forced bus error.
import bus_response_mux_pkg::*;

module bus_response_mux #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    bus_response_mux_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Elaboration-time parameter sanity.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("bus_response_mux: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
    end

    entry_t        in_entry_s;
    entry_t        head_fifo_s;
    entry_t        head_s;
    logic          head_valid_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          error_resp_s;
    logic [31:0]   head_rdata_s;

    logic          cpu_ack_r;
    logic          cpu_error_r;
    logic [31:0]   cpu_rdata_r;
    logic [31:0]   cpu_error_address_r;

    // Build the entry for the request presented this cycle.
    always_comb begin
        in_entry_s.tag     = decode_tag({bus.error_request, bus.imem_request,
                                         bus.hwregs_request, bus.dmem_request});
        in_entry_s.address = bus.cpu_address;
    end

    // Head of line: with an empty FIFO the incoming request is the head, so a
    // same-cycle ack is answered on the next cycle.
    always_comb begin
        head_s       = head_fifo_s;
        head_valid_s = 1'b0;
        if (fifo_empty_s) begin
            head_s       = in_entry_s;
            head_valid_s = bus.cpu_request;
        end else begin
            head_s       = head_fifo_s;
            head_valid_s = 1'b1;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int RAW_W  = $clog2(TIMEOUT + 1);
    localparam int WAIT_W = (RAW_W < 8) ? 8 : ((RAW_W > 16) ? 16 : RAW_W);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_hit_s;

    assign timeout_hit_s = (wait_cnt_r >= WAIT_W'(TIMEOUT));

    // Count cycles the head target request has been waiting for its ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (pop_s || !head_valid_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (head_s.tag != TAG_ERR) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`endif

    // Decide whether the head is answered this cycle, and with what.
    always_comb begin
        pop_s        = 1'b0;
        error_resp_s = 1'b0;
        head_rdata_s = 32'h0000_0000;
        if (head_valid_s) begin
            case (head_s.tag)
                TAG_DMEM: begin
                    pop_s        = bus.dmem_ack;
                    head_rdata_s = bus.dmem_rdata;
                end
                TAG_HWREGS: begin
                    pop_s        = bus.hwregs_ack;
                    head_rdata_s = bus.hwregs_rdata;
                end
                TAG_IMEM: begin
                    pop_s        = bus.imem_ack;
                    head_rdata_s = bus.imem_rdata;
                end
                TAG_ERR: begin
                    pop_s        = 1'b1;
                    error_resp_s = 1'b1;
                    head_rdata_s = 32'h0000_0000;
                end
                default: begin
                    pop_s        = 1'b0;
                    error_resp_s = 1'b0;
                    head_rdata_s = 32'h0000_0000;
                end
            endcase
`ifdef BUS_TIMEOUT_EN
            // A real ack in the same cycle as the timeout takes priority.
            if (!pop_s && timeout_hit_s) begin
                pop_s        = 1'b1;
                error_resp_s = 1'b1;
                head_rdata_s = 32'h0000_0000;
            end else begin
                pop_s        = pop_s;
                error_resp_s = error_resp_s;
                head_rdata_s = head_rdata_s;
            end
`endif
        end else begin
            pop_s        = 1'b0;
            error_resp_s = 1'b0;
            head_rdata_s = 32'h0000_0000;
        end
    end

    // Push/pop qualification; a request answered straight from an empty
    // FIFO never needs to be stored.
    always_comb begin
        push_s      = bus.cpu_request & (~fifo_full_s | pop_s);
        fifo_push_s = push_s & ~(fifo_empty_s & pop_s);
        fifo_pop_s  = pop_s & ~fifo_empty_s;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (in_entry_s),
        .pop       (fifo_pop_s),
        .pop_data  (head_fifo_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Registered CPU response; the error address holds until the next error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_ack_r           <= 1'b0;
            cpu_error_r         <= 1'b0;
            cpu_rdata_r         <= 32'h0000_0000;
            cpu_error_address_r <= 32'h0000_0000;
        end else begin
            cpu_ack_r   <= pop_s;
            cpu_error_r <= pop_s & error_resp_s;
            cpu_rdata_r <= pop_s ? head_rdata_s : 32'h0000_0000;
            if (pop_s && error_resp_s) begin
                cpu_error_address_r <= head_s.address;
            end else begin
                cpu_error_address_r <= cpu_error_address_r;
            end
        end
    end

    assign bus.cpu_stall         = (fifo_count_s == CW'(DEPTH));
    assign bus.cpu_ack           = cpu_ack_r;
    assign bus.cpu_error         = cpu_error_r;
    assign bus.cpu_rdata         = cpu_rdata_r;
    assign bus.cpu_error_address = cpu_error_address_r;
endmodule

// File: tb/tb_bus_response_mux.sv
// Directed, table-driven bench for bus_response_mux (DEPTH=4, TIMEOUT=8).
// Each table row is one clock: inputs applied before the edge, registered
// outputs compared just after it.
module tb_bus_response_mux;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    localparam logic [3:0] NO = 4'b0000;
    localparam logic [3:0] DM = 4'b0001;
    localparam logic [3:0] HW = 4'b0010;
    localparam logic [3:0] IM = 4'b0100;
    localparam logic [3:0] ER = 4'b1000;
    localparam logic [2:0] A0 = 3'b000;
    localparam logic [2:0] AD = 3'b001;
    localparam logic [2:0] AH = 3'b010;
    localparam logic [2:0] AI = 3'b100;

    localparam logic [31:0] RD_D = 32'hDEAD_BEEF;
    localparam logic [31:0] RD_H = 32'h1111_2222;
    localparam logic [31:0] RD_I = 32'h3333_4444;
    localparam logic [31:0] Z    = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bus_response_mux_if bus ();

    bus_response_mux #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [2:0]  acks;
        logic        e_ack;
        logic        e_err;
        logic        e_stall;
        logic [31:0] e_rdata;
        logic [31:0] e_eaddr;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t mk(input logic req, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [2:0] acks,
                                input logic e_ack, input logic e_err, input logic e_stall,
                                input logic [31:0] e_rdata, input logic [31:0] e_eaddr);
        vec_t v;
        v.req = req; v.addr = addr; v.sel = sel; v.acks = acks;
        v.e_ack = e_ack; v.e_err = e_err; v.e_stall = e_stall;
        v.e_rdata = e_rdata; v.e_eaddr = e_eaddr;
        return v;
    endfunction

    task automatic drive(input logic req, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [2:0] acks);
        bus.cpu_request    = req;
        bus.cpu_address    = addr;
        bus.dmem_request   = sel[0];
        bus.hwregs_request = sel[1];
        bus.imem_request   = sel[2];
        bus.error_request  = sel[3];
        bus.dmem_ack       = acks[0];
        bus.hwregs_ack     = acks[1];
        bus.imem_ack       = acks[2];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string name, input logic e_ack, input logic e_err,
                             input logic e_stall, input logic [31:0] e_rdata,
                             input logic [31:0] e_eaddr);
        total++;
        if (bus.cpu_ack === e_ack && bus.cpu_error === e_err && bus.cpu_stall === e_stall &&
            bus.cpu_rdata === e_rdata && bus.cpu_error_address === e_eaddr) begin
            passed++;
        end else begin
            $display("FAIL %s: got ack=%0b err=%0b stall=%0b rdata=%h eaddr=%h, expected ack=%0b err=%0b stall=%0b rdata=%h eaddr=%h",
                     name, bus.cpu_ack, bus.cpu_error, bus.cpu_stall, bus.cpu_rdata,
                     bus.cpu_error_address, e_ack, e_err, e_stall, e_rdata, e_eaddr);
        end
    endtask

    initial begin
        bus.dmem_rdata   = RD_D;
        bus.hwregs_rdata = RD_H;
        bus.imem_rdata   = RD_I;
        drive(1'b0, Z, NO, A0);

        // dmem read, ack three cycles later
        vecs.push_back(mk(1'b1, 32'h0000_0100, DM, A0, 1'b0, 1'b0, 1'b0, Z,    Z));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z,    Z));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z,    Z));
        vecs.push_back(mk(1'b0, Z,             NO, AD, 1'b1, 1'b0, 1'b0, RD_D, Z));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z,    Z));
        // decoder error request; a stray dmem ack must not leak data
        vecs.push_back(mk(1'b1, 32'h8000_0000, ER, AD, 1'b1, 1'b1, 1'b0, Z, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z, 32'h8000_0000));
        // in-order return: early hwregs acks are ignored until dmem is served
        vecs.push_back(mk(1'b1, 32'h0000_0200, DM, A0, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b1, 32'hE000_0010, HW, AH, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b1, 32'hFFFF_0004, IM, AH, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AD | AH, 1'b1, 1'b0, 1'b0, RD_D, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AH, 1'b1, 1'b0, 1'b0, RD_H, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AI, 1'b1, 1'b0, 1'b0, RD_I, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        // fill to DEPTH, push+pop while full, dropped request while full, drain
        vecs.push_back(mk(1'b1, 32'h0000_0010, DM, A0, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b1, 32'h0000_0014, DM, A0, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b1, 32'h0000_0018, DM, A0, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b1, 32'h0000_001C, DM, A0, 1'b0, 1'b0, 1'b1, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b1, 32'hE000_0020, HW, AD, 1'b1, 1'b0, 1'b1, RD_D, 32'h8000_0000));
        vecs.push_back(mk(1'b1, 32'hFFFF_0008, IM, A0, 1'b0, 1'b0, 1'b1, Z,    32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AD, 1'b1, 1'b0, 1'b0, RD_D, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AD, 1'b1, 1'b0, 1'b0, RD_D, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AD, 1'b1, 1'b0, 1'b0, RD_D, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AD | AH, 1'b1, 1'b0, 1'b0, RD_H, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, AI, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        // back-to-back into an empty FIFO
        vecs.push_back(mk(1'b1, 32'h0000_0300, DM, AD, 1'b1, 1'b0, 1'b0, RD_D, 32'h8000_0000));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z,    32'h8000_0000));
        // multiple selects and no select both become errors
        vecs.push_back(mk(1'b1, 32'h0000_0400, DM | HW, AD, 1'b1, 1'b1, 1'b0, Z, 32'h0000_0400));
        vecs.push_back(mk(1'b1, 32'h0000_0500, NO, A0, 1'b1, 1'b1, 1'b0, Z, 32'h0000_0500));
        vecs.push_back(mk(1'b0, Z,             NO, A0, 1'b0, 1'b0, 1'b0, Z, 32'h0000_0500));

        // reset state
        reset = 1'b1;
        tick();
        check_out("reset_state", 1'b0, 1'b0, 1'b0, Z, Z);
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].sel, vecs[i].acks);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_err,
                      vecs[i].e_stall, vecs[i].e_rdata, vecs[i].e_eaddr);
        end

        // reset with two requests outstanding, then stale acks
        drive(1'b1, 32'h0000_0600, DM, A0);
        tick();
        drive(1'b1, 32'h0000_0604, DM, A0);
        tick();
        drive(1'b0, Z, NO, A0);
        check_out("pre_reset", 1'b0, 1'b0, 1'b0, Z, 32'h0000_0500);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 1'b0, 1'b0, 1'b0, Z, Z);
        tick();
        reset = 1'b0;
        drive(1'b0, Z, NO, AD);
        tick();
        check_out("stale_ack_1", 1'b0, 1'b0, 1'b0, Z, Z);
        tick();
        check_out("stale_ack_2", 1'b0, 1'b0, 1'b0, Z, Z);
        drive(1'b0, Z, NO, A0);
        tick();

`ifdef BUS_TIMEOUT_EN
        begin
            int first_hit;
            int n_acks;
            first_hit = -1;
            n_acks    = 0;
            drive(1'b1, 32'hE000_0030, HW, A0);
            tick();
            drive(1'b0, Z, NO, A0);
            check_out("timeout_push", 1'b0, 1'b0, 1'b0, Z, Z);
            for (int k = 1; k <= 12; k++) begin
                tick();
                if (bus.cpu_ack === 1'b1) begin
                    n_acks++;
                    if (first_hit < 0) begin
                        first_hit = k;
                    end
                end
                if (k == TIMEOUT) begin
                    check_out("timeout_resp", 1'b1, 1'b1, 1'b0, Z, 32'hE000_0030);
                end
            end
            total++;
            if (first_hit == TIMEOUT && n_acks == 1) begin
                passed++;
            end else begin
                $display("FAIL timeout_timing: got first ack %0d cycles after push edge (%0d acks), expected %0d (1 ack)",
                         first_hit, n_acks, TIMEOUT);
            end
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
